// File: rtl/lo_sle_pkg.sv
// Shared types and constants for the LO synthesizer serial programming controller.
package lo_sle_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      HIGH,
      PRE_LE,
      LATCH
   } state_e;

   localparam int unsigned XFER_CNT_W    = 16;
   localparam int unsigned BIT_CNT_W     = 6;
   localparam int unsigned CLK_DIV_DEF   = 4;
   localparam int unsigned LE_HOLD_DEF   = 8;
   localparam int unsigned WORD_BITS_DEF = 32;

   // Cycles busy stays high for one transfer: WORD_BITS full sclk periods, PRE_LE, then the latch pulse.
   function automatic int unsigned busy_cycles(input int unsigned clk_div,
                                               input int unsigned le_hold,
                                               input int unsigned word_bits);
      return (2 * word_bits + 1) * clk_div + le_hold;
   endfunction

endpackage

// File: rtl/lo_sle_req_detect.sv
// Start-toggle edge detector with a one-deep pending request that is consumed on launch.
module lo_sle_req_detect (
   input  logic clk,
   input  logic rst,
   input  logic start_tgl,
   input  logic launch,
   output logic req_c
);

   logic tgl_q, tgl_d;
   logic pend_q, pend_d;
   logic req;

   // A launch consumes one request; a fresh toggle arriving alongside a pending launch is kept.
   always_comb begin
      req    = start_tgl ^ tgl_q;
      tgl_d  = start_tgl;
      pend_d = launch ? (pend_q & req) : (pend_q | req);
      req_c  = req | pend_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tgl_q  <= start_tgl;
         pend_q <= 1'b0;
      end else begin
         tgl_q  <= tgl_d;
         pend_q <= pend_d;
      end
   end

endmodule

// File: rtl/lo_sle_serial_ctrl.sv
// Shifts the LO_SLE word MSB-first on lo_sdata/lo_sclk, then pulses lo_sle to latch it.
module lo_sle_serial_ctrl
   import lo_sle_pkg::*;
#(
   parameter int unsigned CLK_DIV   = CLK_DIV_DEF,
   parameter int unsigned LE_HOLD   = LE_HOLD_DEF,
   parameter int unsigned WORD_BITS = WORD_BITS_DEF
) (
   input  logic                  user_clk,
   input  logic                  user_rst,
   input  logic [31:0]           data_word,
   input  logic                  start_tgl,
   output logic                  lo_sclk,
   output logic                  lo_sdata,
   output logic                  lo_sle,
   output logic                  busy,
   output logic                  done,
   output logic [XFER_CNT_W-1:0] xfer_count
);

   localparam int unsigned DIV_MAX = (CLK_DIV > LE_HOLD) ? CLK_DIV : LE_HOLD;
   localparam int unsigned DIV_W   = (DIV_MAX > 1) ? $clog2(DIV_MAX) : 1;

   localparam logic [DIV_W-1:0]     DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [DIV_W-1:0]     LE_LAST  = DIV_W'(LE_HOLD - 1);
   localparam logic [BIT_CNT_W-1:0] BIT_LAST = BIT_CNT_W'(WORD_BITS - 1);

   state_e                  state_q, state_d;
   logic [DIV_W-1:0]        div_cnt_q, div_cnt_d;
   logic [BIT_CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
   logic [WORD_BITS-1:0]    shreg_q, shreg_d;
   logic                    sclk_q, sclk_d;
   logic                    sle_q, sle_d;
   logic                    busy_q, busy_d;
   logic                    done_q, done_d;
   logic [XFER_CNT_W-1:0]   xfer_cnt_q, xfer_cnt_d;
   logic                    req_c;
   logic                    launch_c;

   lo_sle_req_detect u_req_detect (
      .clk       (user_clk),
      .rst       (user_rst),
      .start_tgl (start_tgl),
      .launch    (launch_c),
      .req_c     (req_c)
   );

   // lo_sdata is the shift register MSB, so it only moves when HIGH exits (sclk falling).
   always_comb begin
      state_d    = state_q;
      div_cnt_d  = div_cnt_q + DIV_W'(1);
      bit_cnt_d  = bit_cnt_q;
      shreg_d    = shreg_q;
      sclk_d     = sclk_q;
      sle_d      = sle_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      xfer_cnt_d = xfer_cnt_q;
      launch_c   = 1'b0;

      case (state_q)
         IDLE: begin
            div_cnt_d = '0;
            if (req_c) begin
               launch_c  = 1'b1;
               shreg_d   = data_word[WORD_BITS-1:0];
               busy_d    = 1'b1;
               bit_cnt_d = '0;
               state_d   = SETUP;
            end
         end
         SETUP: begin
            if (div_cnt_q == DIV_LAST) begin
               div_cnt_d = '0;
               sclk_d    = 1'b1;
               state_d   = HIGH;
            end
         end
         HIGH: begin
            if (div_cnt_q == DIV_LAST) begin
               div_cnt_d = '0;
               sclk_d    = 1'b0;
               if (bit_cnt_q == BIT_LAST) begin
                  shreg_d = '0;
                  state_d = PRE_LE;
               end else begin
                  shreg_d   = shreg_q << 1;
                  bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                  state_d   = SETUP;
               end
            end
         end
         PRE_LE: begin
            if (div_cnt_q == DIV_LAST) begin
               div_cnt_d = '0;
               sle_d     = 1'b1;
               state_d   = LATCH;
            end
         end
         LATCH: begin
            if (div_cnt_q == LE_LAST) begin
               div_cnt_d  = '0;
               sle_d      = 1'b0;
               busy_d     = 1'b0;
               done_d     = 1'b1;
               xfer_cnt_d = xfer_cnt_q + XFER_CNT_W'(1);
               state_d    = IDLE;
            end
         end
         default: begin
            div_cnt_d = '0;
            state_d   = IDLE;
         end
      endcase
   end

   always_ff @(posedge user_clk) begin
      if (user_rst) begin
         state_q    <= IDLE;
         div_cnt_q  <= '0;
         bit_cnt_q  <= '0;
         shreg_q    <= '0;
         sclk_q     <= 1'b0;
         sle_q      <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         xfer_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         div_cnt_q  <= div_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         shreg_q    <= shreg_d;
         sclk_q     <= sclk_d;
         sle_q      <= sle_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         xfer_cnt_q <= xfer_cnt_d;
      end
   end

   assign lo_sclk    = sclk_q;
   assign lo_sdata   = shreg_q[WORD_BITS-1];
   assign lo_sle     = sle_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign xfer_count = xfer_cnt_q;

endmodule

// File: tb/tb_lo_sle_serial_ctrl.sv
// Scoreboard bench: stimulus queues expected transfers, a negedge monitor decodes the serial bus and checks them.
module tb_lo_sle_serial_ctrl;
   import lo_sle_pkg::*;

   localparam int A_DIV  = int'(CLK_DIV_DEF);
   localparam int A_HOLD = int'(LE_HOLD_DEF);
   localparam int A_BITS = 32;
   localparam int B_DIV  = 1;
   localparam int B_HOLD = 1;
   localparam int B_BITS = 24;
   localparam int A_BUSY = int'(busy_cycles(CLK_DIV_DEF, LE_HOLD_DEF, 32));
   localparam int B_BUSY = int'(busy_cycles(1, 1, 24));

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int total = 0;
   int bad   = 0;

   logic        rst_a, tgl_a, sclk_a, sdata_a, sle_a, busy_a, done_a;
   logic [31:0] word_a;
   logic [15:0] cnt_a;
   logic        rst_b, tgl_b, sclk_b, sdata_b, sle_b, busy_b, done_b;
   logic [31:0] word_b;
   logic [15:0] cnt_b;

   lo_sle_serial_ctrl dut_a (
      .user_clk (clk), .user_rst (rst_a), .data_word (word_a), .start_tgl (tgl_a),
      .lo_sclk (sclk_a), .lo_sdata (sdata_a), .lo_sle (sle_a), .busy (busy_a),
      .done (done_a), .xfer_count (cnt_a)
   );

   lo_sle_serial_ctrl #(.CLK_DIV(1), .LE_HOLD(1), .WORD_BITS(24)) dut_b (
      .user_clk (clk), .user_rst (rst_b), .data_word (word_b), .start_tgl (tgl_b),
      .lo_sclk (sclk_b), .lo_sdata (sdata_b), .lo_sle (sle_b), .busy (busy_b),
      .done (done_b), .xfer_count (cnt_b)
   );

   // start >= 0: absolute cycle busy must rise; -2: must rise the cycle after the previous done
   typedef struct {
      logic [31:0] word;
      int          start;
   } item_t;

   item_t q_a[$];
   item_t q_b[$];

   typedef struct {
      bit          in_x;
      bit          have;
      int          busy_len;
      int          sle_len;
      int          rises;
      int          last_rise;
      int          last_chg;
      int          done_cyc;
      logic [31:0] bits;
      logic        psclk;
      logic        psdata;
      logic        pbusy;
      logic [15:0] exp_cnt;
      item_t       cur;
   } mon_t;

   mon_t ms[2];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
      end
   endtask

   task automatic mon_step(input int id, input int wb, input int cdiv, input int hold, input int bexp,
                           input logic rst, input logic sclk, input logic sdata, input logic sle,
                           input logic busy, input logic done, input logic [15:0] cnt);
      mon_t        m;
      string       p;
      int          qs;
      logic [31:0] mask;
      m    = ms[id];
      p    = (id == 0) ? "a_" : "b_";
      mask = (wb >= 32) ? 32'hFFFF_FFFF : ((32'd1 << wb) - 32'd1);
      if (rst) begin
         m.in_x     = 1'b0;
         m.have     = 1'b0;
         m.exp_cnt  = 16'h0000;
         m.rises    = 0;
         m.done_cyc = -10;
         m.psclk    = 1'b0;
         m.psdata   = 1'b0;
         m.pbusy    = 1'b0;
      end else begin
         if (busy && !m.pbusy) begin
            qs = (id == 0) ? q_a.size() : q_b.size();
            chk({p, "launch_expected"}, 32'(qs > 0), 32'd1);
            m.have = 1'b0;
            if (qs > 0) begin
               if (id == 0) m.cur = q_a.pop_front();
               else         m.cur = q_b.pop_front();
               m.have = 1'b1;
               if (m.cur.start >= 0) chk({p, "launch_cycle"}, 32'(cyc), 32'(m.cur.start));
               else                  chk({p, "launch_after_done"}, 32'(cyc), 32'(m.done_cyc + 1));
            end
            m.in_x     = 1'b1;
            m.busy_len = 0;
            m.sle_len  = 0;
            m.rises    = 0;
            m.bits     = '0;
            m.last_chg = cyc;
         end
         if (busy) m.busy_len++;
         if (sle) begin
            m.sle_len++;
            chk({p, "sle_while_sclk"}, 32'(sclk), 32'd0);
         end
         if (sclk && !m.psclk) begin
            m.rises++;
            m.bits = {m.bits[30:0], sdata};
            chk({p, "sclk_outside_busy"}, 32'(busy), 32'd1);
            chk({p, "sdata_setup"}, 32'(cyc - m.last_chg >= cdiv), 32'd1);
            m.last_rise = cyc;
         end
         if (sdata !== m.psdata) begin
            if (m.rises > 0) chk({p, "sdata_hold"}, 32'(cyc - m.last_rise >= cdiv), 32'd1);
            m.last_chg = cyc;
         end
         if (done) begin
            chk({p, "done_in_xfer"}, 32'(m.in_x), 32'd1);
            chk({p, "done_busy_low"}, 32'(busy), 32'd0);
            chk({p, "busy_len"}, 32'(m.busy_len), 32'(bexp));
            chk({p, "sclk_rises"}, 32'(m.rises), 32'(wb));
            chk({p, "sle_len"}, 32'(m.sle_len), 32'(hold));
            if (m.have) chk({p, "word"}, m.bits & mask, m.cur.word & mask);
            m.exp_cnt = m.exp_cnt + 16'd1;
            chk({p, "xfer_count"}, 32'(cnt), 32'(m.exp_cnt));
            m.done_cyc = cyc;
            m.in_x     = 1'b0;
            m.have     = 1'b0;
         end
         m.psclk  = sclk;
         m.psdata = sdata;
         m.pbusy  = busy;
      end
      ms[id] = m;
   endtask

   always @(negedge clk) begin
      mon_step(0, A_BITS, A_DIV, A_HOLD, A_BUSY, rst_a, sclk_a, sdata_a, sle_a, busy_a, done_a, cnt_a);
      mon_step(1, B_BITS, B_DIV, B_HOLD, B_BUSY, rst_b, sclk_b, sdata_b, sle_b, busy_b, done_b, cnt_b);
   end

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_idle(input int id, input int budget);
      int  n;
      bit  pend;
      n    = 0;
      pend = 1'b1;
      while (pend && n < budget) begin
         tick(1);
         n++;
         if (id == 0) pend = (q_a.size() > 0) || ms[0].in_x || busy_a;
         else         pend = (q_b.size() > 0) || ms[1].in_x || busy_b;
      end
      chk((id == 0) ? "a_idle_timeout" : "b_idle_timeout", 32'(pend), 32'd0);
   endtask

   task automatic chk_zero_a(input string tag);
      chk({tag, "_sclk"}, 32'(sclk_a), 32'd0);
      chk({tag, "_sdata"}, 32'(sdata_a), 32'd0);
      chk({tag, "_sle"}, 32'(sle_a), 32'd0);
      chk({tag, "_busy"}, 32'(busy_a), 32'd0);
      chk({tag, "_done"}, 32'(done_a), 32'd0);
      chk({tag, "_count"}, 32'(cnt_a), 32'd0);
   endtask

   initial begin
      logic [31:0] w, w4, lw;
      int          s, m, d;

      rst_a = 1'b1; tgl_a = 1'b0; word_a = '0;
      rst_b = 1'b1; tgl_b = 1'b0; word_b = '0;
      tick(3);
      chk_zero_a("a_reset");
      chk("b_reset_busy", 32'(busy_b), 32'd0);
      chk("b_reset_count", 32'(cnt_b), 32'd0);
      chk("b_reset_sdata", 32'(sdata_b), 32'd0);
      rst_a = 1'b0;
      rst_b = 1'b0;
      tick(2);

      // single transfer at the defaults
      word_a = 32'h8000_0001;
      q_a.push_back('{word_a, cyc + 1});
      tgl_a = ~tgl_a;
      wait_idle(0, 400);
      chk("a_count_t1", 32'(cnt_a), 32'd1);

      // back-to-back toggles plus a mid-transfer toggle collapse into one pending transfer
      w = $urandom;
      word_a = w;
      q_a.push_back('{w, cyc + 1});
      tgl_a = ~tgl_a;
      tick(1);
      tgl_a = ~tgl_a;
      q_a.push_back('{32'h1234_5678, -2});
      tick(100);
      word_a = 32'h1234_5678;
      tick(20);
      tgl_a = ~tgl_a;
      wait_idle(0, 1000);
      tick(300);
      chk("a_count_t2", 32'(cnt_a), 32'd3);

      // reset during bit 10; toggle in the last reset cycle must be ignored
      word_a = $urandom;
      q_a.push_back('{word_a, cyc + 1});
      tgl_a = ~tgl_a;
      tick(84);
      rst_a = 1'b1;
      tick(1);
      chk_zero_a("a_midreset");
      tgl_a = ~tgl_a;
      tick(1);
      rst_a = 1'b0;
      tick(300);
      chk("a_post_reset_busy", 32'(busy_a), 32'd0);
      chk("a_post_reset_count", 32'(cnt_a), 32'd0);

      // short configuration: 24 bits, one-cycle phases
      word_b = 32'hFFAB_CDEF;
      q_b.push_back('{word_b, cyc + 1});
      tgl_b = ~tgl_b;
      wait_idle(1, 200);

      // request on LATCH exit, then another on the following launch cycle
      w  = $urandom;
      w4 = $urandom;
      word_b = w;
      s = cyc + 1;
      q_b.push_back('{w, s});
      tgl_b = ~tgl_b;
      tick(B_BUSY);
      q_b.push_back('{w, -2});
      tgl_b = ~tgl_b;
      tick(1);
      q_b.push_back('{w4, -2});
      tgl_b = ~tgl_b;
      tick(20);
      word_b = w4;
      wait_idle(1, 400);

      // counter wrap
      force dut_b.xfer_cnt_q = 16'hFFFF;
      ms[1].exp_cnt = 16'hFFFF;
      tick(1);
      release dut_b.xfer_cnt_q;
      tick(1);
      chk("b_count_preload", 32'(cnt_b), 32'h0000_FFFF);
      word_b = $urandom;
      q_b.push_back('{word_b, cyc + 1});
      tgl_b = ~tgl_b;
      wait_idle(1, 200);
      chk("b_count_wrap", 32'(cnt_b), 32'd0);

      // random transfers with random extra toggles while busy
      repeat (20) begin
         tick($urandom_range(0, 5));
         w = $urandom;
         word_b = w;
         q_b.push_back('{w, cyc + 1});
         tgl_b = ~tgl_b;
         m  = $urandom_range(0, 3);
         lw = w;
         for (int i = 0; i < m; i++) begin
            d = $urandom_range(1, 12);
            tick(d);
            lw = $urandom;
            word_b = lw;
            tgl_b = ~tgl_b;
         end
         if (m > 0) q_b.push_back('{lw, -2});
         wait_idle(1, 300);
      end

      tick(5);
      chk("a_queue_empty", 32'(q_a.size()), 32'd0);
      chk("b_queue_empty", 32'(q_b.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
